serial_rx_ctrl: RTL



---
 rtl/serial_rx_ctrl.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/serial_rx_ctrl.sv
// -----------------------------------------------------------------------------
// serial_rx_ctrl
//
// Receive-side sequencer for a UART-style serial link. Detects the falling
// edge of a start bit, confirms it at mid-bit, then times each data bit and
// emits a one-cycle shift_enable pulse to an external serial-to-parallel
// shift register (NUM_BITS wide, shifting toward MSB). At the stop bit the
// register contents are captured into a holding buffer with ready, overrun
// and framing status.
//
// Optional feature (macro RX_PARITY_EN): inserts a PARITY state between DATA
// and STOP. The parity bit is even, and a mismatch raises parity_error when
// the word is loaded. Without the macro, parity_error is tied low.
//
// Parameters:
//   NUM_BITS      data bits per frame, equal to the shift register width (2..16)
//   CLKS_PER_BIT  clock cycles per bit period (>= 4)
//
// Ports:
//   clk            system clock, rising edge
//   n_rst          synchronous active-low reset
//   serial_in      synchronized serial line, idle high
//   sr_data        parallel output of the external shift register
//   data_read      one-cycle pulse: bus has consumed rx_data
//   shift_enable   one-cycle pulse to the shift register's shift enable
//   rx_data        last good received word
//   data_ready     rx_data holds unread data
//   overrun_error  a word was overwritten before it was read
//   framing_error  the last frame had a stop bit of 0
//   parity_error   parity mismatch on the last loaded word
//   busy           high in every state except IDLE
//
// Handshake: data_ready is a level that stays high until a data_read pulse
// arrives while it is set. A stop-bit load in the same cycle as data_read
// takes priority, so the freshly loaded word stays marked as unread.
// -----------------------------------------------------------------------------
module serial_rx_ctrl #(
    parameter int NUM_BITS     = 8,
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                serial_in,
    input  logic [NUM_BITS-1:0] sr_data,
    input  logic                data_read,
    output logic                shift_enable,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                data_ready,
    output logic                overrun_error,
    output logic                framing_error,
    output logic                parity_error,
    output logic                busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int TW   = $clog2(CLKS_PER_BIT);
    localparam int CW   = $clog2(NUM_BITS + 1);

    localparam logic [TW-1:0] HALF_M1  = TW'(HALF - 1);
    localparam logic [TW-1:0] BIT_M1   = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_CHK = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_CHK = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd4
    } state_t;
`endif

    state_t        state, next_state;
    logic [TW-1:0] timer, timer_nxt;
    logic [CW-1:0] bit_cnt, bit_cnt_nxt;
    logic          prev_in;
    logic          start_edge;
    logic          shift_pulse;
    logic          stop_sample;
    logic          good_stop;
    logic          rx_busy;

    assign start_edge = prev_in & ~serial_in;

    // ------------------------------------------------------------------
    // Next-state and timing control
    // ------------------------------------------------------------------
`ifdef RX_PARITY_EN
    logic par_sample;
`endif

    always_comb begin
        next_state  = state;
        timer_nxt   = timer;
        bit_cnt_nxt = bit_cnt;
        shift_pulse = 1'b0;
        stop_sample = 1'b0;
`ifdef RX_PARITY_EN
        par_sample  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start_edge) begin
                    next_state = START_CHK;
                    timer_nxt  = '0;
                end
            end
            START_CHK: begin
                // Mid-bit check filters short low glitches on the line.
                if (timer == HALF_M1) begin
                    timer_nxt = '0;
                    if (!serial_in) begin
                        next_state  = DATA;
                        bit_cnt_nxt = '0;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            DATA: begin
                if (timer == BIT_M1) begin
                    shift_pulse = 1'b1;
                    timer_nxt   = '0;
                    bit_cnt_nxt = bit_cnt + CW'(1);
                    if (bit_cnt == LAST_BIT) begin
`ifdef RX_PARITY_EN
                        next_state = PARITY;
`else
                        next_state = STOP;
`endif
                    end
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (timer == BIT_M1) begin
                    par_sample = 1'b1;
                    timer_nxt  = '0;
                    next_state = STOP;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
`endif
            STOP: begin
                if (timer == BIT_M1) begin
                    stop_sample = 1'b1;
                    timer_nxt   = '0;
                    next_state  = IDLE;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: begin
                next_state = IDLE;
                timer_nxt  = '0;
            end
        endcase
    end

    // Gated by n_rst so a frame abandoned by reset never shifts again,
    // even in the cycle the reset is being applied.
    assign shift_enable = shift_pulse & n_rst;
    assign good_stop    = stop_sample & serial_in;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            prev_in <= 1'b1;
            rx_busy <= 1'b0;
        end else begin
            state   <= next_state;
            timer   <= timer_nxt;
            bit_cnt <= bit_cnt_nxt;
            prev_in <= serial_in;
            rx_busy <= (next_state != IDLE);
        end
    end

    assign busy = rx_busy;

    // ------------------------------------------------------------------
    // Holding buffer and status
    // ------------------------------------------------------------------
`ifdef RX_PARITY_EN
    logic parity_bit;
    logic parity_err_q;
`endif

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rx_data       <= '1;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
`ifdef RX_PARITY_EN
            parity_bit    <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            if (state == IDLE && start_edge) begin
                framing_error <= 1'b0;
`ifdef RX_PARITY_EN
                parity_err_q  <= 1'b0;
`endif
            end
`ifdef RX_PARITY_EN
            if (par_sample) begin
                parity_bit <= serial_in;
            end
`endif
            if (good_stop) begin
                // Load wins over a simultaneous read; overrun only when an
                // unread word is replaced without being consumed.
                rx_data       <= sr_data;
                data_ready    <= 1'b1;
                overrun_error <= data_ready & ~data_read;
`ifdef RX_PARITY_EN
                parity_err_q  <= (^sr_data) ^ parity_bit;
`endif
            end else begin
                if (stop_sample) begin
                    framing_error <= 1'b1;
                end
                if (data_read && data_ready) begin
                    data_ready    <= 1'b0;
                    overrun_error <= 1'b0;
                end
            end
        end
    end

`ifdef RX_PARITY_EN
    assign parity_error = parity_err_q;
`else
    assign parity_error = 1'b0;
`endif

endmodule
